// File: rtl/bram_cfg_dp_if.sv
// ---------------------------------------------------------------------------
// bram_cfg_dp_if
//   Bus bundle for the configurable simple-dual-port BRAM tile.
//   Carries the write request (wr_en/wr_addr/wr_data), the read request
//   (rd_en/rd_addr), the read response (rd_data/rd_valid) and the
//   clear-sweep status (busy).
//   Address layout on both ports: [ADDR_WIDTH+1:2] word, [1:0] slice select.
//   modport master : the fabric side issuing reads/writes
//   modport slave  : the RAM tile
// ---------------------------------------------------------------------------
interface bram_cfg_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    wr_en;
    logic [ADDR_WIDTH+1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    rd_en;
    logic [ADDR_WIDTH+1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;
    logic                    busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/bram_cfg_dp.sv
// ---------------------------------------------------------------------------
// bram_cfg_dp
//   Parametrised simple-dual-port block RAM with per-port aspect ratio
//   (full / half / quarter word), sub-word addressing, read enable + valid,
//   selectable read-during-write policy, optional output register stage and
//   optional clear-on-reset sweep.
//
// Parameters
//   DATA_WIDTH   word width, multiple of 32 (quarter slice is byte aligned)
//   ADDR_WIDTH   word address bits, DEPTH = 2**ADDR_WIDTH
//   WRITE_FIRST  1: same-word read during write returns the newly written
//                slices; 0: returns the old word
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   cfg_wr_width   write aspect: 00 full, 01 half, 10 quarter, 11 full
//   cfg_rd_width   read aspect, same encoding
//   cfg_always_we  write every cycle regardless of wr_en
//   cfg_out_reg    adds one output register stage (read latency 2)
//   bus            bram_cfg_dp_if.slave: wr/rd requests, rd_data/rd_valid, busy
//
// Compile-time option
//   BRAM_CLEAR_ON_RESET_EN : reset starts a sweep that writes 0 to every word
//   (busy high for DEPTH cycles after rst deasserts). Without it busy is 0 and
//   memory contents after power-up are undefined.
//
// Storage is split into four quarter-width lanes so each lane can be written
// independently; this maps onto byte-write-enable block RAM.
// ---------------------------------------------------------------------------
module bram_cfg_dp #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WRITE_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cfg_wr_width,
    input  logic [1:0]          cfg_rd_width,
    input  logic                cfg_always_we,
    input  logic                cfg_out_reg,
    bram_cfg_dp_if.slave        bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int HW    = DATA_WIDTH / 2;
    localparam int QW    = DATA_WIDTH / 4;

    localparam logic [1:0] W_HALF    = 2'b01;
    localparam logic [1:0] W_QUARTER = 2'b10;

    // ------------------------------------------------------------------
    // Clear-sweep control
    // ------------------------------------------------------------------
    logic                  busy_int;
    logic                  clearing;
    logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef BRAM_CLEAR_ON_RESET_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] clr_ptr_reg;
    logic                  busy_reg;

    // Reset (including mid-sweep) always restarts the sweep at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    if (&clr_ptr_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy_int = busy_reg;
    assign clearing = (state_reg == ST_CLEAR);
    assign clr_addr = clr_ptr_reg;
`else
    assign busy_int = 1'b0;
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign bus.busy = busy_int;

    // ------------------------------------------------------------------
    // Write lane decode
    // ------------------------------------------------------------------
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_word;
    logic [1:0]            wr_slice;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign wr_word  = bus.wr_addr[ADDR_WIDTH+1:2];
    assign wr_slice = bus.wr_addr[1:0];
    assign wr_req   = (bus.wr_en | cfg_always_we) & ~busy_int;

    always_comb begin
        mem_we    = 4'b0000;
        mem_waddr = wr_word;
        mem_wdata = bus.wr_data;
        case (cfg_wr_width)
            W_HALF: begin
                // Low half of wr_data is replicated to both halves; the
                // lane enables pick which half is actually written.
                mem_wdata = {bus.wr_data[HW-1:0], bus.wr_data[HW-1:0]};
                if (wr_req) begin
                    mem_we = wr_slice[0] ? 4'b1100 : 4'b0011;
                end
            end
            W_QUARTER: begin
                mem_wdata = {4{bus.wr_data[QW-1:0]}};
                if (wr_req) begin
                    mem_we = 4'b0001 << wr_slice;
                end
            end
            default: begin
                if (wr_req) begin
                    mem_we = 4'b1111;
                end
            end
        endcase
        if (clearing) begin
            mem_we    = 4'b1111;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
    end

    // ------------------------------------------------------------------
    // Read request, stage 1 (memory read register)
    // ------------------------------------------------------------------
    logic                  rd_accept;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] s1_word;
    logic                  s1_valid_reg;
    logic [1:0]            s1_slice_reg;
    logic [1:0]            s1_width_reg;

    assign rd_accept = bus.rd_en & ~busy_int;
    assign rd_word   = bus.rd_addr[ADDR_WIDTH+1:2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [QW-1:0] mem [DEPTH];
            logic [QW-1:0] q_reg;
            logic          bypass;

            // Only lanes written this edge bypass; untouched lanes of the
            // same word still return the stored (old) value.
            assign bypass = (WRITE_FIRST != 0) && mem_we[gi] && (mem_waddr == rd_word);

            always_ff @(posedge clk) begin
                if (mem_we[gi]) begin
                    mem[mem_waddr] <= mem_wdata[gi*QW +: QW];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (rd_accept) begin
                    if (bypass) begin
                        q_reg <= mem_wdata[gi*QW +: QW];
                    end else begin
                        q_reg <= mem[rd_word];
                    end
                end
            end

            assign s1_word[gi*QW +: QW] = q_reg;
        end
    endgenerate

    // Slice select and read aspect travel with the request so a read is
    // formatted with the configuration it was issued under.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_slice_reg <= 2'b00;
            s1_width_reg <= 2'b00;
        end else begin
            s1_valid_reg <= rd_accept;
            if (rd_accept) begin
                s1_slice_reg <= bus.rd_addr[1:0];
                s1_width_reg <= cfg_rd_width;
            end
        end
    end

    // ------------------------------------------------------------------
    // Narrow-read formatting: selected slice in low bits, rest zero
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fmt_data;

    always_comb begin
        fmt_data = '0;
        case (s1_width_reg)
            W_HALF: begin
                fmt_data[HW-1:0] = s1_slice_reg[0] ? s1_word[DATA_WIDTH-1:HW]
                                                   : s1_word[HW-1:0];
            end
            W_QUARTER: begin
                case (s1_slice_reg)
                    2'd0:    fmt_data[QW-1:0] = s1_word[0*QW +: QW];
                    2'd1:    fmt_data[QW-1:0] = s1_word[1*QW +: QW];
                    2'd2:    fmt_data[QW-1:0] = s1_word[2*QW +: QW];
                    default: fmt_data[QW-1:0] = s1_word[3*QW +: QW];
                endcase
            end
            default: begin
                fmt_data = s1_word;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Optional output register (stage 2)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] s2_data_reg;
    logic                  s2_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_data_reg  <= '0;
            s2_valid_reg <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg <= fmt_data;
            end
        end
    end

    // Stage-1 registers only load on an accepted read, so fmt_data holds the
    // last result between reads just like s2_data_reg does.
    assign bus.rd_data  = cfg_out_reg ? s2_data_reg  : fmt_data;
    assign bus.rd_valid = cfg_out_reg ? s2_valid_reg : s1_valid_reg;

endmodule

// File: tb/tb_bram_cfg_dp.sv
// ---------------------------------------------------------------------------
// tb_bram_cfg_dp
//   Two instances share one stimulus stream: dut_wf (WRITE_FIRST=1) and
//   dut_rf (WRITE_FIRST=0). Each read pushes the expected data and arrival
//   cycle for both instances into queues; independent monitors pop and
//   compare whenever rd_valid is seen.
// ---------------------------------------------------------------------------
module tb_bram_cfg_dp;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] F = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] Q = 2'b10;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cfg_wr_width = F;
    logic [1:0] cfg_rd_width = F;
    logic       cfg_always_we = 1'b0;
    logic       cfg_out_reg = 1'b0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q_wf[$];
    exp_t q_rf[$];

    bram_cfg_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_wf ();
    bram_cfg_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_rf ();

    assign bus_rf.wr_en   = bus_wf.wr_en;
    assign bus_rf.wr_addr = bus_wf.wr_addr;
    assign bus_rf.wr_data = bus_wf.wr_data;
    assign bus_rf.rd_en   = bus_wf.rd_en;
    assign bus_rf.rd_addr = bus_wf.rd_addr;

    bram_cfg_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_FIRST(1)) dut_wf (
        .clk           (clk),
        .rst           (rst),
        .cfg_wr_width  (cfg_wr_width),
        .cfg_rd_width  (cfg_rd_width),
        .cfg_always_we (cfg_always_we),
        .cfg_out_reg   (cfg_out_reg),
        .bus           (bus_wf)
    );

    bram_cfg_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_FIRST(0)) dut_rf (
        .clk           (clk),
        .rst           (rst),
        .cfg_wr_width  (cfg_wr_width),
        .cfg_rd_width  (cfg_rd_width),
        .cfg_always_we (cfg_always_we),
        .cfg_out_reg   (cfg_out_reg),
        .bus           (bus_rf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (q_wf.size() > 0 && q_wf[0].cyc < cyc) begin
            e = q_wf.pop_front();
            n_checks++; n_fail++;
            $display("FAIL wf_missing_valid cyc=%0d expected data=%h at cyc=%0d", cyc, e.data, e.cyc);
        end
        if (bus_wf.rd_valid) begin
            n_checks++;
            if (q_wf.size() == 0) begin
                n_fail++;
                $display("FAIL wf_unexpected_valid cyc=%0d got data=%h required no valid", cyc, bus_wf.rd_data);
            end else begin
                e = q_wf.pop_front();
                if (bus_wf.rd_data !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL wf_read got data=%h cyc=%0d required data=%h cyc=%0d",
                             bus_wf.rd_data, cyc, e.data, e.cyc);
                end else begin
                    $display("wf read ok data=%h cyc=%0d", bus_wf.rd_data, cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q_rf.size() > 0 && q_rf[0].cyc < cyc) begin
            e = q_rf.pop_front();
            n_checks++; n_fail++;
            $display("FAIL rf_missing_valid cyc=%0d expected data=%h at cyc=%0d", cyc, e.data, e.cyc);
        end
        if (bus_rf.rd_valid) begin
            n_checks++;
            if (q_rf.size() == 0) begin
                n_fail++;
                $display("FAIL rf_unexpected_valid cyc=%0d got data=%h required no valid", cyc, bus_rf.rd_data);
            end else begin
                e = q_rf.pop_front();
                if (bus_rf.rd_data !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL rf_read got data=%h cyc=%0d required data=%h cyc=%0d",
                             bus_rf.rd_data, cyc, e.data, e.cyc);
                end else begin
                    $display("rf read ok data=%h cyc=%0d", bus_rf.rd_data, cyc);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end else begin
            $display("check %s ok value=%h", name, act);
        end
    endtask

    // One clock cycle of stimulus; a read pushes the expected response of
    // both instances (e_wf for WRITE_FIRST=1, e_rf for WRITE_FIRST=0).
    task automatic step(input logic [1:0] wrw, input logic [1:0] rdw,
                        input logic we, input int wword, input logic [1:0] wsl, input logic [DW-1:0] wd,
                        input logic re, input int rword, input logic [1:0] rsl,
                        input logic [DW-1:0] e_wf, input logic [DW-1:0] e_rf);
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        int            lat;
        wa = wword[AW-1:0];
        ra = rword[AW-1:0];
        lat = cfg_out_reg ? 2 : 1;
        cfg_wr_width   = wrw;
        cfg_rd_width   = rdw;
        bus_wf.wr_en   = we;
        bus_wf.wr_addr = {wa, wsl};
        bus_wf.wr_data = wd;
        bus_wf.rd_en   = re;
        bus_wf.rd_addr = {ra, rsl};
        if (re) begin
            q_wf.push_back('{data: e_wf, cyc: cyc + lat});
            q_rf.push_back('{data: e_rf, cyc: cyc + lat});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(F, F, 1'b0, 0, 2'b00, '0, 1'b0, 0, 2'b00, '0, '0);
    endtask

    task automatic wr_full(input int word, input logic [DW-1:0] d);
        step(F, F, 1'b1, word, 2'b00, d, 1'b0, 0, 2'b00, '0, '0);
    endtask

    task automatic rd(input logic [1:0] rdw, input int word, input logic [1:0] sl, input logic [DW-1:0] e);
        step(F, rdw, 1'b0, 0, 2'b00, '0, 1'b1, word, sl, e, e);
    endtask

    // Bounded wait for busy to drop; returns number of busy cycles seen.
    task automatic wait_idle(output int n);
        n = 0;
        while (bus_wf.busy && n < DEPTH + 16) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nb;
        bus_wf.wr_en   = 1'b0;
        bus_wf.wr_addr = '0;
        bus_wf.wr_data = '0;
        bus_wf.rd_en   = 1'b0;
        bus_wf.rd_addr = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_valid", {31'b0, bus_wf.rd_valid}, 32'd0);
        chk("reset_rd_data", bus_wf.rd_data, 32'd0);
        rst = 1'b0;
        wait_idle(nb);
        chk("idle_busy_low", {31'b0, bus_wf.busy}, 32'd0);

        // Full-word write then read, latency 1
        wr_full(5, 32'hDEADBEEF);
        rd(F, 5, 2'b00, 32'hDEADBEEF);
        idle(2);
        chk("hold_rd_data", bus_wf.rd_data, 32'hDEADBEEF);

        // Quarter writes into word 7, then reads at all aspects
        step(Q, F, 1'b1, 7, 2'd0, 32'hFFFFFF11, 1'b0, 0, 2'b00, '0, '0);
        step(Q, F, 1'b1, 7, 2'd1, 32'hFFFFFF22, 1'b0, 0, 2'b00, '0, '0);
        step(Q, F, 1'b1, 7, 2'd2, 32'hFFFFFF33, 1'b0, 0, 2'b00, '0, '0);
        step(Q, F, 1'b1, 7, 2'd3, 32'hFFFFFF44, 1'b0, 0, 2'b00, '0, '0);
        rd(F, 7, 2'b00, 32'h44332211);
        rd(Q, 7, 2'd2,  32'h00000033);
        rd(Q, 7, 2'd3,  32'h00000044);
        rd(H, 7, 2'b01, 32'h00004433);
        rd(H, 7, 2'b00, 32'h00002211);
        rd(H, 7, 2'b10, 32'h00002211);

        // Half write with addr[1] set selects upper half via addr[0] only
        wr_full(8, 32'h01234567);
        step(H, F, 1'b1, 8, 2'b11, 32'hFFFFBEEF, 1'b0, 0, 2'b00, '0, '0);
        rd(F, 8, 2'b00, 32'hBEEF4567);

        // Read during write, same word, same edge
        wr_full(3, 32'h12345678);
        step(F, F, 1'b1, 3, 2'b00, 32'hAAAAAAAA, 1'b1, 3, 2'b00, 32'hAAAAAAAA, 32'h12345678);
        wr_full(3, 32'h12345678);
        step(H, F, 1'b1, 3, 2'b01, 32'h0000AAAA, 1'b1, 3, 2'b00, 32'hAAAA5678, 32'h12345678);
        step(Q, Q, 1'b1, 3, 2'd0, 32'h00000055, 1'b1, 3, 2'd0, 32'h00000055, 32'h00000078);
        rd(F, 3, 2'b00, 32'hAAAA5655);
        // Different words on the same edge are independent
        step(F, F, 1'b1, 4, 2'b00, 32'h44444444, 1'b1, 3, 2'b00, 32'hAAAA5655, 32'hAAAA5655);
        rd(F, 4, 2'b00, 32'h44444444);
        idle(2);

        // Output register: back-to-back reads, latency 2
        wr_full(0, 32'hA0000000);
        wr_full(1, 32'hA0000001);
        wr_full(2, 32'hA0000002);
        cfg_out_reg = 1'b1;
        idle(1);
        rd(F, 0, 2'b00, 32'hA0000000);
        rd(F, 1, 2'b00, 32'hA0000001);
        rd(F, 2, 2'b00, 32'hA0000002);
        idle(3);
        chk("outreg_hold_rd_data", bus_wf.rd_data, 32'hA0000002);

        // Reset with a read in flight: first completes before reset edge,
        // second must be dropped
        rd(F, 0, 2'b00, 32'hA0000000);
        rd(F, 1, 2'b00, 32'hA0000001);
        rst = 1'b1;
        idle(1);
        q_wf.delete();
        q_rf.delete();
        chk("inflight_rst_rd_valid", {31'b0, bus_wf.rd_valid}, 32'd0);
        chk("inflight_rst_rd_data", bus_wf.rd_data, 32'd0);
        rst = 1'b0;
        wait_idle(nb);
        idle(2);
        chk("post_rst_rd_valid", {31'b0, bus_wf.rd_valid}, 32'd0);
        cfg_out_reg = 1'b0;

        // always_we writes without wr_en; plain wr_en=0 writes nothing
        cfg_always_we = 1'b1;
        step(F, F, 1'b0, 9,  2'b00, 32'h99999999, 1'b0, 0, 2'b00, '0, '0);
        step(F, F, 1'b0, 10, 2'b00, 32'hAAAA0000, 1'b0, 0, 2'b00, '0, '0);
        cfg_always_we = 1'b0;
        step(F, F, 1'b0, 9,  2'b00, 32'hFFFFFFFF, 1'b0, 0, 2'b00, '0, '0);
        step(F, F, 1'b0, 10, 2'b00, 32'hFFFFFFFF, 1'b0, 0, 2'b00, '0, '0);
        rd(F, 9,  2'b00, 32'h99999999);
        rd(F, 10, 2'b00, 32'hAAAA0000);
        idle(2);

`ifdef BRAM_CLEAR_ON_RESET_EN
        // Clear sweep: busy for DEPTH cycles, reads ignored, memory zeroed
        wr_full(5, 32'h5555AAAA);
        wr_full(DEPTH - 1, 32'hCAFEF00D);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        bus_wf.rd_en = 1'b1;
        wait_idle(nb);
        bus_wf.rd_en = 1'b0;
        chk("clear_busy_cycles", nb, DEPTH);
        rd(F, 5, 2'b00, 32'h0);
        rd(F, DEPTH - 1, 2'b00, 32'h0);
        rd(F, 9, 2'b00, 32'h0);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        repeat (DEPTH / 2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        wait_idle(nb);
        chk("restart_busy_cycles", nb, DEPTH);
        idle(2);
`endif

        idle(3);
        chk("wf_queue_drained", q_wf.size(), 32'd0);
        chk("rf_queue_drained", q_rf.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout got=running required=finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end
endmodule
